rtc_ad_bus_writer: RTL and testbench
====================================

# rtc_ad_bus_writer

Bus-cycle generator directly downstream of the RTC write sequencer. It turns each sequencer write request (`wr_en` plus a byte on `din`) into one complete write cycle on the RTC's multiplexed address/data bus: an address phase latched by ALE, then a data phase strobed by WR_n. It paces the sequencer through the `req_addr`, `req_data` and `done` handshake; these drive the sequencer's DIR, DAT and cambio_estado inputs.

## Interface
- `T_PH`, 10 — width of each bus sub-phase in clk cycles; legal range 1..255. The phase counter is 8 bits.
- `clk` input 1 — system clock; all state changes on the rising edge.
- `reset` input 1 — asynchronous, active-high.
- `wr_en` input 1 — write request from the sequencer (its E_esc).
- `din` input 8 — byte from the sequencer: the address after `req_addr`, the data after `req_data`.
- `req_addr` output 1 — one-cycle pulse asking the sequencer to present the address byte.
- `req_data` output 1 — one-cycle pulse asking the sequencer to present the data byte.
- `done` output 1 — one-cycle pulse when the bus cycle is complete.
- `busy` output 1 — high in every state except IDLE and REARM.
- `cs_n` output 1 — RTC chip select, active-low.
- `ale` output 1 — address latch enable, active-high.
- `wr_n` output 1 — write strobe, active-low.
- `rd_n` output 1 — read strobe; held at 1 (write-only block).
- `ad_out` output 8 — value driven onto the AD bus.
- `ad_oe` output 1 — AD bus output enable; the top-level tristate uses it.

## Operation
- All outputs are decoded from registers only; no output has a combinational path from an input.
- States and transitions (`cnt` counts down the current sub-phase):
  - IDLE: if `wr_en`=1, go to REQ_A.
  - REQ_A: `req_addr`=1 for this one cycle. Next state LOAD_A.
  - LOAD_A: `addr_reg` <= `din`. Next state ADDR, with `cnt` <= T_PH-1.
  - ADDR: `cs_n`=0, `ale`=1, `ad_oe`=1, `ad_out`=`addr_reg`. When `cnt`=0, go to A_HOLD with `cnt` reloaded.
  - A_HOLD: `cs_n`=0, `ale`=0, `ad_oe`=1, `ad_out`=`addr_reg`. When `cnt`=0, go to REQ_D.
  - REQ_D: `cs_n`=0, `ad_oe`=0, `req_data`=1 for this one cycle. Next state LOAD_D.
  - LOAD_D: `cs_n`=0. `data_reg` <= `din`. Next state WR, with `cnt` reloaded.
  - WR: `cs_n`=0, `wr_n`=0, `ad_oe`=1, `ad_out`=`data_reg`. When `cnt`=0, go to D_HOLD with `cnt` reloaded.
  - D_HOLD: `cs_n`=0, `wr_n`=1, `ad_oe`=1, `ad_out`=`data_reg`. When `cnt`=0, go to DONE.
  - DONE: `cs_n`=1, `ad_oe`=0, `done`=1 for this one cycle. Next state REARM.
  - REARM: wait for `wr_en`=0, then go to IDLE. This blocks the sequencer's one-cycle E_esc low gap from being read as a retrigger.
- The one-cycle LOAD states are required. The sequencer registers its byte on the edge that ends REQ_x, so `din` is valid only during LOAD_x.
- Abort: if `wr_en`=0 in any state from REQ_A through D_HOLD, the next state is IDLE.
  - On entering IDLE, all bus outputs return to their idle values.
  - No `done` pulse is issued.
- Outside ADDR, A_HOLD, WR and D_HOLD, `ad_out` holds its last value while `ad_oe`=0.

## Timing
- Reset values:
  - State IDLE, `cnt`=0, `addr_reg`=0, `data_reg`=0.
  - `cs_n`=1, `ale`=0, `wr_n`=1, `rd_n`=1, `ad_oe`=0, `ad_out`=0x00.
  - `req_addr`=0, `req_data`=0, `done`=0, `busy`=0.
- Reset is honoured in any state, including mid-cycle.
- Cycle numbering: edge 0 is the edge on which IDLE samples `wr_en`=1. Each state begins at:
  - REQ_A at edge 1, LOAD_A at edge 2, ADDR at edge 3.
  - A_HOLD at 3+T, REQ_D at 3+2T, LOAD_D at 4+2T, WR at 5+2T.
  - D_HOLD at 5+3T, DONE at 5+4T, REARM at 6+4T.
- With T=10, `done` is high for the cycle starting at edge 45.
- Phase widths: ALE high, address hold, WR_n low and data hold are each exactly T cycles.
- `cs_n` is low continuously from ADDR through D_HOLD, i.e. 4T+2 cycles.
- With T_PH=1, every phase lasts 1 cycle; there is no zero-length phase.

## Test plan
- Basic write, T_PH=10, stub sequencer drives 0x21 then 0x05:
  - `req_addr` pulses at edge 1 and `req_data` at edge 23.
  - AD shows 0x21 while `ale`=1 for 10 cycles, then 0x05 while `wr_n`=0 for 10 cycles.
  - `done` pulses at edge 45.
- Full sequencer handshake: connect the real write sequencer and run 8 back-to-back bytes.
  - Each byte produces exactly one bus cycle.
  - The E_esc gap after each `done` causes no double write.
- Abort: drop `wr_en` during WR.
  - Next cycle: `cs_n`=1, `wr_n`=1, `ad_oe`=0, state IDLE.
  - No `done` pulse.
- Async reset during ADDR: all outputs take reset values immediately, without waiting for a clock edge.
- T_PH=1: `done` pulses at edge 9; `ale` and `wr_n` pulses are each 1 cycle wide.
- REARM hold: keep `wr_en`=1 after `done`.
  - No new `req_addr` is issued.
  - A 0→1 transition on `wr_en` then starts a new cycle.

Source files
------------

// File: rtl/rtc_ad_bus_writer_if.sv
// Multiplexed address/data write-bus bundle between the RTC write sequencer
// and the bus-cycle generator. Handshake: wr_en/din in; req_addr/req_data/done
// back to the sequencer. Bus: cs_n, ale, wr_n, rd_n, ad_out, ad_oe.
interface rtc_ad_bus_writer_if;
  logic       wr_en;     // write request (sequencer E_esc)
  logic [7:0] din;       // address byte after req_addr, data byte after req_data
  logic       req_addr;  // one-cycle request for the address byte
  logic       req_data;  // one-cycle request for the data byte
  logic       done;      // one-cycle bus-cycle-complete pulse
  logic       busy;      // bus cycle in progress
  logic       cs_n;      // RTC chip select, active-low
  logic       ale;       // address latch enable
  logic       wr_n;      // write strobe, active-low
  logic       rd_n;      // read strobe, always inactive
  logic [7:0] ad_out;    // value for the AD bus
  logic       ad_oe;     // AD bus output enable for the top-level tristate

  // Bus-cycle generator side.
  modport slave (
    input  wr_en, din,
    output req_addr, req_data, done, busy, cs_n, ale, wr_n, rd_n, ad_out, ad_oe
  );

  // Sequencer / RTC side.
  modport master (
    output wr_en, din,
    input  req_addr, req_data, done, busy, cs_n, ale, wr_n, rd_n, ad_out, ad_oe
  );
endinterface

// File: rtl/rtc_ad_bus_writer.sv
// rtc_ad_bus_writer: turns each sequencer write request into one RTC write
// cycle (ALE address phase, then WR_n data phase), each sub-phase T_PH clocks.
// Ports: clk, reset (async, active-high), bus (rtc_ad_bus_writer_if.slave).
module rtc_ad_bus_writer #(
  parameter int unsigned T_PH = 10  // sub-phase width in clk cycles, 1..255
) (
  input  logic                 clk,
  input  logic                 reset,
  rtc_ad_bus_writer_if.slave   bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_A, S_LOAD_A, S_ADDR, S_A_HOLD, S_REQ_D,
    S_LOAD_D, S_WR, S_D_HOLD, S_DONE, S_REARM
  } state_t;

  localparam logic [7:0] CNT_RELOAD = 8'(T_PH - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] ad_hold_q;  // last value driven, kept while the bus is released

  logic       req_addr, req_data, done, busy, cs_n, ale, wr_n, ad_oe;
  logic [7:0] ad_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      addr_q    <= 8'd0;
      data_q    <= 8'd0;
      ad_hold_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ad_hold_q <= ad_out;
    end
  end

  // Next state. din is only valid during the LOAD states because the
  // sequencer registers its byte on the edge that ends the REQ pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE:   if (bus.wr_en) state_d = S_REQ_A;
      S_REQ_A:  state_d = S_LOAD_A;
      S_LOAD_A: begin
        addr_d  = bus.din;
        cnt_d   = CNT_RELOAD;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = CNT_RELOAD;
          state_d = S_A_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_A_HOLD: begin
        if (cnt_q == 8'd0) state_d = S_REQ_D;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_REQ_D:  state_d = S_LOAD_D;
      S_LOAD_D: begin
        data_d  = bus.din;
        cnt_d   = CNT_RELOAD;
        state_d = S_WR;
      end
      S_WR: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = CNT_RELOAD;
          state_d = S_D_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_D_HOLD: begin
        if (cnt_q == 8'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_DONE:   state_d = S_REARM;
      // Wait for the sequencer's E_esc gap so a still-high wr_en after done
      // is not taken as a new request.
      S_REARM:  if (!bus.wr_en) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Sequencer withdrew the request mid-cycle: release the bus, no done.
    if (!bus.wr_en && (state_q inside {S_REQ_A, S_LOAD_A, S_ADDR, S_A_HOLD,
                                       S_REQ_D, S_LOAD_D, S_WR, S_D_HOLD})) begin
      state_d = S_IDLE;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_addr = 1'b0;
    req_data = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    cs_n     = 1'b1;
    ale      = 1'b0;
    wr_n     = 1'b1;
    ad_oe    = 1'b0;
    ad_out   = ad_hold_q;
    case (state_q)
      S_IDLE, S_REARM: busy = 1'b0;
      S_REQ_A:  req_addr = 1'b1;
      S_ADDR: begin
        cs_n = 1'b0; ale = 1'b1; ad_oe = 1'b1; ad_out = addr_q;
      end
      S_A_HOLD: begin
        cs_n = 1'b0; ad_oe = 1'b1; ad_out = addr_q;
      end
      S_REQ_D: begin
        cs_n = 1'b0; req_data = 1'b1;
      end
      S_LOAD_D: cs_n = 1'b0;
      S_WR: begin
        cs_n = 1'b0; wr_n = 1'b0; ad_oe = 1'b1; ad_out = data_q;
      end
      S_D_HOLD: begin
        cs_n = 1'b0; ad_oe = 1'b1; ad_out = data_q;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  assign bus.req_addr = req_addr;
  assign bus.req_data = req_data;
  assign bus.done     = done;
  assign bus.busy     = busy;
  assign bus.cs_n     = cs_n;
  assign bus.ale      = ale;
  assign bus.wr_n     = wr_n;
  assign bus.rd_n     = 1'b1;
  assign bus.ad_out   = ad_out;
  assign bus.ad_oe    = ad_oe;

endmodule

// File: tb/tb_rtc_ad_bus_writer.sv
// Testbench for rtc_ad_bus_writer: two instances (T_PH=10 and T_PH=1) driven
// by a stub write sequencer; per-cycle outputs compared with a timeline model
// derived from the bus-cycle edge numbering.
module tb_rtc_ad_bus_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] din;
  logic       sel;  // 0: drive the T_PH=10 instance, 1: the T_PH=1 instance

  always #5 clk = ~clk;

  rtc_ad_bus_writer_if if10 ();
  rtc_ad_bus_writer_if if1 ();

  assign if10.wr_en = sel ? 1'b0 : wr_en;
  assign if10.din   = din;
  assign if1.wr_en  = sel ? wr_en : 1'b0;
  assign if1.din    = din;

  rtc_ad_bus_writer #(.T_PH(10)) dut10 (.clk(clk), .reset(reset), .bus(if10));
  rtc_ad_bus_writer #(.T_PH(1))  dut1  (.clk(clk), .reset(reset), .bus(if1));

  typedef struct packed {
    logic       req_addr;
    logic       req_data;
    logic       done;
    logic       busy;
    logic       cs_n;
    logic       ale;
    logic       wr_n;
    logic       rd_n;
    logic       ad_oe;
    logic [7:0] ad;
  } vec_t;

  vec_t obs10, obs1, obs;
  assign obs10 = {if10.req_addr, if10.req_data, if10.done, if10.busy, if10.cs_n,
                  if10.ale, if10.wr_n, if10.rd_n, if10.ad_oe, if10.ad_out};
  assign obs1  = {if1.req_addr, if1.req_data, if1.done, if1.busy, if1.cs_n,
                  if1.ale, if1.wr_n, if1.rd_n, if1.ad_oe, if1.ad_out};
  assign obs   = sel ? obs1 : obs10;

  int         errors = 0;
  int         checks = 0;
  vec_t       obs_q[$];
  logic [7:0] model_ad [2];  // AD value each instance currently holds
  int         done_k, done_cnt, req_a_cnt, ale_cnt, wrn_cnt, csn_cnt;

  // ---------------- reference model ----------------
  function automatic vec_t idle_vec(input logic [7:0] ad);
    vec_t v;
    v = '0;
    v.cs_n = 1'b1; v.wr_n = 1'b1; v.rd_n = 1'b1; v.ad = ad;
    return v;
  endfunction

  // AD value on cycle k of a write: previous value until ADDR starts,
  // the address until WR starts, then the data.
  function automatic logic [7:0] ad_of(input int t, input int k, input logic [7:0] prev,
                                       input logic [7:0] addr, input logic [7:0] data);
    if (k < 3)       return prev;
    if (k < 5 + 2*t) return addr;
    return data;
  endfunction

  // Expected outputs in the cycle starting at edge k (edge 0 = wr_en raised).
  function automatic vec_t exp_cycle(input int t, input int k, input logic [7:0] prev,
                                     input logic [7:0] addr, input logic [7:0] data,
                                     input int abort_k);
    vec_t v;
    if (abort_k > 0 && k > abort_k) return idle_vec(ad_of(t, abort_k, prev, addr, data));
    v = idle_vec(ad_of(t, k, prev, addr, data));
    if (k >= 6 + 4*t) return v;
    v.busy = 1'b1;
    if (k == 1) v.req_addr = 1'b1;
    else if (k >= 3 && k < 3 + t) begin v.cs_n = 0; v.ale = 1; v.ad_oe = 1; end
    else if (k >= 3 + t && k < 3 + 2*t) begin v.cs_n = 0; v.ad_oe = 1; end
    else if (k == 3 + 2*t) begin v.cs_n = 0; v.req_data = 1; end
    else if (k == 4 + 2*t) v.cs_n = 0;
    else if (k >= 5 + 2*t && k < 5 + 3*t) begin v.cs_n = 0; v.wr_n = 0; v.ad_oe = 1; end
    else if (k >= 5 + 3*t && k < 5 + 4*t) begin v.cs_n = 0; v.ad_oe = 1; end
    else if (k == 5 + 4*t) v.done = 1'b1;
    return v;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stub sequencer: raises wr_en, returns each byte on the edge that ends the
  // matching request pulse, optionally drops wr_en after cycle abort_k, and
  // otherwise holds wr_en for 'hold' REARM cycles before its one-cycle gap.
  // Records the cycles 1..end in obs_q.
  task automatic run_write(input logic [7:0] addr, input logic [7:0] data,
                           input int abort_k, input int hold);
    int t;
    int kmax;
    bit saw_ra, saw_rd;
    t = sel ? 1 : 10;
    kmax = (abort_k > 0) ? abort_k + 3 : 6 + 4*t + hold;
    obs_q.delete();
    done_k = -1; done_cnt = 0; req_a_cnt = 0; ale_cnt = 0; wrn_cnt = 0; csn_cnt = 0;
    saw_ra = 1'b0; saw_rd = 1'b0;
    wr_en = 1'b1;
    din = 8'($urandom);
    for (int k = 1; k <= kmax; k++) begin
      step();
      obs_q.push_back(obs);
      if (obs.done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
      end
      if (obs.req_addr) req_a_cnt++;
      if (obs.ale)      ale_cnt++;
      if (!obs.wr_n)    wrn_cnt++;
      if (!obs.cs_n)    csn_cnt++;
      din = saw_ra ? addr : (saw_rd ? data : 8'($urandom));
      saw_ra = obs.req_addr;
      saw_rd = obs.req_data;
      if (abort_k > 0 && k == abort_k) wr_en = 1'b0;
      if (abort_k == 0 && k == 5 + 4*t + hold) wr_en = 1'b0;
    end
    wr_en = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel = 1'b0; wr_en = 1'b0; din = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs10 !== idle_vec(8'h00)) begin
      errors++; $display("FAIL reset_t10: got %h expected %h", obs10, idle_vec(8'h00));
    end
    checks++;
    if (obs1 !== idle_vec(8'h00)) begin
      errors++; $display("FAIL reset_t1: got %h expected %h", obs1, idle_vec(8'h00));
    end
    reset = 1'b0;
    step(); step();
    checks++;
    if (obs10 !== idle_vec(8'h00)) begin
      errors++; $display("FAIL reset_idle: got %h expected %h", obs10, idle_vec(8'h00));
    end
    model_ad[0] = 8'h00; model_ad[1] = 8'h00;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_write(8'h21, 8'h05, 0, 1);
    for (int i = 0; i < obs_q.size(); i++) begin
      vec_t e;
      e = exp_cycle(10, i + 1, model_ad[0], 8'h21, 8'h05, 0);
      checks++;
      if (obs_q[i] !== e) begin
        errors++; $display("FAIL basic cycle %0d: got %h expected %h", i + 1, obs_q[i], e);
      end
    end
    checks++;
    if (obs_q[0].req_addr !== 1'b1) begin
      errors++; $display("FAIL basic_req_addr_edge1: got %b expected 1", obs_q[0].req_addr);
    end
    checks++;
    if (obs_q[22].req_data !== 1'b1) begin
      errors++; $display("FAIL basic_req_data_edge23: got %b expected 1", obs_q[22].req_data);
    end
    checks++;
    if (done_k !== 45) begin
      errors++; $display("FAIL basic_done_edge: got %0d expected 45", done_k);
    end
    checks++;
    if (ale_cnt !== 10 || wrn_cnt !== 10 || csn_cnt !== 42) begin
      errors++;
      $display("FAIL basic_widths: ale=%0d wr_n_low=%0d cs_n_low=%0d expected 10 10 42",
               ale_cnt, wrn_cnt, csn_cnt);
    end
    model_ad[0] = 8'h05;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    for (int n = 0; n < 8; n++) begin
      logic [7:0] a, d;
      a = 8'($urandom); d = 8'($urandom);
      run_write(a, d, 0, 1);
      for (int i = 0; i < obs_q.size(); i++) begin
        vec_t e;
        e = exp_cycle(10, i + 1, model_ad[0], a, d, 0);
        checks++;
        if (obs_q[i] !== e) begin
          errors++;
          $display("FAIL b2b byte %0d cycle %0d: got %h expected %h", n, i + 1, obs_q[i], e);
        end
      end
      checks++;
      if (done_cnt !== 1 || req_a_cnt !== 1) begin
        errors++;
        $display("FAIL b2b_single_cycle byte %0d: done=%0d req_addr=%0d expected 1 1",
                 n, done_cnt, req_a_cnt);
      end
      model_ad[0] = d;
    end
  endtask

  task automatic test_abort(input int lo, input int hi, input int reps);
    sel = 1'b0;
    for (int n = 0; n < reps; n++) begin
      logic [7:0] a, d;
      int ak;
      a = 8'($urandom); d = 8'($urandom);
      ak = $urandom_range(hi, lo);
      run_write(a, d, ak, 0);
      for (int i = 0; i < obs_q.size(); i++) begin
        vec_t e;
        e = exp_cycle(10, i + 1, model_ad[0], a, d, ak);
        checks++;
        if (obs_q[i] !== e) begin
          errors++;
          $display("FAIL abort@%0d cycle %0d: got %h expected %h", ak, i + 1, obs_q[i], e);
        end
      end
      checks++;
      if (obs_q[ak].cs_n !== 1'b1 || obs_q[ak].wr_n !== 1'b1 ||
          obs_q[ak].ad_oe !== 1'b0 || obs_q[ak].busy !== 1'b0 || done_cnt !== 0) begin
        errors++;
        $display("FAIL abort_release@%0d: cs_n=%b wr_n=%b ad_oe=%b busy=%b done=%0d expected 1 1 0 0 0",
                 ak, obs_q[ak].cs_n, obs_q[ak].wr_n, obs_q[ak].ad_oe, obs_q[ak].busy, done_cnt);
      end
      model_ad[0] = ad_of(10, ak, model_ad[0], a, d);
    end
  endtask

  task automatic test_async_reset();
    int kk;
    sel = 1'b0;
    kk = 3 + $urandom_range(9, 0);
    wr_en = 1'b1;
    din = 8'($urandom);
    for (int k = 1; k <= kk; k++) begin
      step();
      din = 8'($urandom);
    end
    checks++;
    if (obs10.ale !== 1'b1) begin
      errors++; $display("FAIL async_pre_in_addr: ale=%b expected 1", obs10.ale);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs10 !== idle_vec(8'h00)) begin
      errors++; $display("FAIL async_reset_immediate: got %h expected %h", obs10, idle_vec(8'h00));
    end
    wr_en = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++;
    if (obs10 !== idle_vec(8'h00)) begin
      errors++; $display("FAIL async_reset_after: got %h expected %h", obs10, idle_vec(8'h00));
    end
    model_ad[0] = 8'h00; model_ad[1] = 8'h00;
  endtask

  task automatic test_tph1();
    logic [7:0] a, d;
    sel = 1'b1;
    a = 8'($urandom); d = 8'($urandom);
    run_write(a, d, 0, 1);
    for (int i = 0; i < obs_q.size(); i++) begin
      vec_t e;
      e = exp_cycle(1, i + 1, model_ad[1], a, d, 0);
      checks++;
      if (obs_q[i] !== e) begin
        errors++; $display("FAIL tph1 cycle %0d: got %h expected %h", i + 1, obs_q[i], e);
      end
    end
    checks++;
    if (done_k !== 9) begin
      errors++; $display("FAIL tph1_done_edge: got %0d expected 9", done_k);
    end
    checks++;
    if (ale_cnt !== 1 || wrn_cnt !== 1 || csn_cnt !== 6) begin
      errors++;
      $display("FAIL tph1_widths: ale=%0d wr_n_low=%0d cs_n_low=%0d expected 1 1 6",
               ale_cnt, wrn_cnt, csn_cnt);
    end
    model_ad[1] = d;
    sel = 1'b0;
  endtask

  task automatic test_rearm_hold();
    int h;
    logic [7:0] a, d;
    sel = 1'b0;
    h = $urandom_range(8, 3);
    a = 8'($urandom); d = 8'($urandom);
    run_write(a, d, 0, h);
    for (int i = 0; i < obs_q.size(); i++) begin
      vec_t e;
      e = exp_cycle(10, i + 1, model_ad[0], a, d, 0);
      checks++;
      if (obs_q[i] !== e) begin
        errors++; $display("FAIL rearm cycle %0d: got %h expected %h", i + 1, obs_q[i], e);
      end
    end
    checks++;
    if (req_a_cnt !== 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL rearm_no_retrigger: req_addr=%0d done=%0d expected 1 1", req_a_cnt, done_cnt);
    end
    model_ad[0] = d;
    a = 8'($urandom); d = 8'($urandom);
    run_write(a, d, 0, 1);
    checks++;
    if (done_k !== 45 || obs_q[0].req_addr !== 1'b1) begin
      errors++;
      $display("FAIL rearm_restart: done_edge=%0d req_addr1=%b expected 45 1",
               done_k, obs_q[0].req_addr);
    end
    model_ad[0] = d;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_abort(25, 34, 2);   // drop wr_en during WR
    test_abort(1, 44, 4);    // drop wr_en anywhere from REQ_A to D_HOLD
    test_async_reset();
    test_tph1();
    test_rearm_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
